spi_rfid_ctrl: RTL

SPI_RFID_CTRL -- requirements
Module: spi_rfid_ctrl

---
 rtl/spi_rfid_pkg.sv | 21 ++
 rtl/spi_byte_shift.sv | 53 +++++
 rtl/spi_rfid_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/spi_rfid_pkg.sv
// Shared FSM encoding and transfer constants for the SPI RFID reader controller.
package spi_rfid_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_ADDR,
        ST_DATA,
        ST_CS_HOLD,
        ST_DONE
    } state_e;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // Reader command byte: direction bit, 6-bit register address, trailing zero.
    function automatic logic [7:0] addr_byte(input logic rw, input logic [5:0] addr);
        return {rw, addr, 1'b0};
    endfunction

endpackage

// File: rtl/spi_byte_shift.sv
// 8-bit MSB-first shifter: parallel load, serial out on shift, serial in captured
// on sample and folded into the low end on the following shift.
module spi_byte_shift (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_byte,
    input  logic       shift_en,
    input  logic       sample_en,
    input  logic       sdi,
    output logic       sdo,
    output logic [7:0] rx_byte,
    output logic       byte_done
);

    logic [7:0] sr_q, sr_d;
    logic [2:0] bit_q, bit_d;
    logic       smp_q, smp_d;

    always_comb begin
        sr_d  = sr_q;
        bit_d = bit_q;
        smp_d = smp_q;
        if (load) begin
            sr_d  = load_byte;
            bit_d = 3'd0;
        end else if (shift_en) begin
            sr_d  = {sr_q[6:0], smp_q};
            bit_d = bit_q + 3'd1;
        end
        if (sample_en) begin
            smp_d = sdi;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q  <= 8'h00;
            bit_q <= 3'd0;
            smp_q <= 1'b0;
        end else begin
            sr_q  <= sr_d;
            bit_q <= bit_d;
            smp_q <= smp_d;
        end
    end

    assign sdo       = sr_q[7];
    assign rx_byte   = sr_q;
    // Strobes on the shift that completes the eighth bit of the current byte.
    assign byte_done = shift_en && (bit_q == 3'd7);

endmodule

// File: rtl/spi_rfid_ctrl.sv
// SPI mode-0 master for single-register reads/writes to an RFID reader:
// one address byte followed by one data byte, framed by cs_n setup/hold gaps.
module spi_rfid_ctrl #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       init,
    input  logic       rw,
    input  logic [5:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       sck,
    output logic       cs_n,
    output logic       mosi,
    input  logic       miso
);
    import spi_rfid_pkg::*;

    localparam logic [7:0] HP_LAST = 8'(CLK_DIV - 1);

    state_e     state_q, state_d;
    logic [7:0] hp_cnt_q, hp_cnt_d;
    logic [7:0] rdata_q, rdata_d;
    logic [7:0] wdata_q, wdata_d;
    logic       rw_q, rw_d;
    logic       sck_q, sck_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic       start, hp_end, shift_phase, sck_rise, sck_fall;
    logic       load, sample_en, sdo, byte_done;
    logic [7:0] load_byte, rx_byte;

    assign start       = (state_q == ST_IDLE) && init;
    assign hp_end      = (hp_cnt_q == HP_LAST);
    assign shift_phase = (state_q == ST_ADDR) || (state_q == ST_DATA);
    assign sck_rise    = shift_phase && hp_end && !sck_q;
    assign sck_fall    = shift_phase && hp_end && sck_q;

    // State register and all sequencing flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            hp_cnt_q <= 8'h00;
            rdata_q  <= 8'h00;
            wdata_q  <= 8'h00;
            rw_q     <= 1'b0;
            sck_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hp_cnt_q <= hp_cnt_d;
            rdata_q  <= rdata_d;
            wdata_q  <= wdata_d;
            rw_q     <= rw_d;
            sck_q    <= sck_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (init) state_d = ST_CS_SETUP;
            ST_CS_SETUP: if (hp_end) state_d = ST_ADDR;
            ST_ADDR:     if (byte_done) state_d = ST_DATA;
            ST_DATA:     if (byte_done) state_d = ST_CS_HOLD;
            ST_CS_HOLD:  if (hp_end) state_d = ST_DONE;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Divider, SCK, request latches and status flops
    always_comb begin
        hp_cnt_d = 8'h00;
        sck_d    = 1'b0;
        rdata_d  = rdata_q;
        wdata_d  = wdata_q;
        rw_d     = rw_q;
        busy_d   = busy_q;
        done_d   = (state_q == ST_DONE);

        if (state_q != ST_IDLE && state_q != ST_DONE) begin
            hp_cnt_d = hp_end ? 8'h00 : hp_cnt_q + 8'h01;
        end
        // Sixteen toggles per byte always leave sck low at the phase boundary.
        if (shift_phase) begin
            sck_d = hp_end ? ~sck_q : sck_q;
        end
        if (start) begin
            rw_d    = rw;
            wdata_d = wdata;
            busy_d  = 1'b1;
        end
        // done is registered off ST_DONE, so busy drops on that same edge.
        if (state_q == ST_DONE) begin
            busy_d = 1'b0;
        end
        if (state_q == ST_CS_HOLD && hp_end && rw_q == RW_READ) begin
            rdata_d = rx_byte;
        end
    end

    // Output and shifter control logic
    always_comb begin
        cs_n      = !(state_q == ST_CS_SETUP || shift_phase);
        mosi      = (state_q == ST_CS_SETUP || shift_phase) ? sdo : 1'b0;
        load      = start || (state_q == ST_ADDR && byte_done);
        sample_en = sck_rise && (state_q == ST_DATA);
        load_byte = start ? addr_byte(rw, addr)
                          : ((rw_q == RW_WRITE) ? wdata_q : 8'h00);
    end

    spi_byte_shift u_shift (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_byte (load_byte),
        .shift_en  (sck_fall),
        .sample_en (sample_en),
        .sdi       (miso),
        .sdo       (sdo),
        .rx_byte   (rx_byte),
        .byte_done (byte_done)
    );

    assign rdata = rdata_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign sck   = sck_q;

endmodule
